// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: word/address widths, ALU opcodes and B-operand shift codes.
package cpu_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned REG_ADDR_W = 3;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    AND  = 2'b10,
    NOTB = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    LSL1 = 2'b01,
    LSR1 = 2'b10,
    ASR1 = 2'b11
  } shift_t;

endpackage

// File: rtl/regfile.sv
// General register file: two combinational read ports, one synchronous write port,
// synchronous active-low clear of every entry.
module regfile
  import cpu_pkg::*;
#(
  parameter int unsigned DW   = WORD_W,
  parameter int unsigned NREG = NUM_REGS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(NREG)-1:0]  raddr_a,
  input  logic [$clog2(NREG)-1:0]  raddr_b,
  output logic [DW-1:0]            rdata_a_c,
  output logic [DW-1:0]            rdata_b_c
);

  logic [DW-1:0] mem [NREG];

  // Storage: clear wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a_c = mem[raddr_a];
  assign rdata_b_c = mem[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: reads sources with write-back forwarding,
// selects zero/immediate, shifts B and holds the result in a one-entry output register.
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DW   = WORD_W,
  parameter int unsigned NREG = NUM_REGS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(NREG)-1:0]  req_rn,
  input  logic [$clog2(NREG)-1:0]  req_rm,
  input  logic                     req_zero_a,
  input  logic                     req_use_imm,
  input  logic [DW-1:0]            req_imm,
  input  logic [1:0]               req_shift,
  input  logic [1:0]               req_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            val_A,
  output logic [DW-1:0]            val_B,
  output alu_op_t                  ALU_op,
  input  logic                     wb_en,
  input  logic [$clog2(NREG)-1:0]  wb_addr,
  input  logic [DW-1:0]            wb_data
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          load;
  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic [DW-1:0] b_src;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (wb_en),
    .waddr     (wb_addr),
    .wdata     (wb_data),
    .raddr_a   (req_rn),
    .raddr_b   (req_rm),
    .rdata_a_c (rf_a),
    .rdata_b_c (rf_b)
  );

  // Ready depends only on the output register occupancy and the consumer.
  assign req_ready = (state_q == EMPTY) || out_ready;
  assign out_valid = (state_q == FULL);

  // Next-state: load whenever a request transfers; drain when consumed with nothing behind.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (req_valid) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (req_valid) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Operand formation: forwarding read, zero/immediate select, then the B shifter.
  always_comb begin
    rd_a  = (wb_en && (wb_addr == req_rn)) ? wb_data : rf_a;
    rd_b  = (wb_en && (wb_addr == req_rm)) ? wb_data : rf_b;
    op_a  = req_zero_a ? '0 : rd_a;
    b_src = req_use_imm ? req_imm : rd_b;
    op_b  = b_src;
    case (shift_t'(req_shift))
      NONE:    op_b = b_src;
      LSL1:    op_b = {b_src[DW-2:0], 1'b0};
      LSR1:    op_b = {1'b0, b_src[DW-1:1]};
      ASR1:    op_b = {b_src[DW-1], b_src[DW-1:1]};
      default: op_b = b_src;
    endcase
  end

  // State and output register; captured operands hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      val_A   <= '0;
      val_B   <= '0;
      ALU_op  <= ADD;
    end else begin
      state_q <= state_d;
      if (load) begin
        val_A  <= op_a;
        val_B  <= op_b;
        ALU_op <= alu_op_t'(req_op);
      end
    end
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch stage sitting directly upstream of the ALU in the simple CPU datapath. It holds the 8×16-bit general register file and accepts one operation request per cycle over a valid/ready handshake. For each request it reads up to two source registers, optionally substitutes an immediate and shifts the B operand, then registers `val_A`, `val_B` and `ALU_op` for the ALU. The ALU result is written back through a dedicated port with same-cycle forwarding.

## Interface
- `DW`, default 16: datapath width; must equal the ALU width.
- `NREG`, default 8: register count; address width is `$clog2(NREG)` = 3.
- `clk` input, 1 bit: the only clock. All state updates on its rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `req_valid` input, 1 bit: a request is present.
- `req_ready` output, 1 bit: the stage accepts a request this cycle.
- `req_rn` input, 3 bits: A-source register.
- `req_rm` input, 3 bits: B-source register.
- `req_zero_a` input, 1 bit: drive A = 0 instead of `R[rn]`.
- `req_use_imm` input, 1 bit: B source is `req_imm` instead of `R[rm]`.
- `req_imm` input, 16 bits: immediate, already sign-extended upstream.
- `req_shift` input, 2 bits: B shift. 00 = none, 01 = LSL1, 10 = LSR1 (zero fill), 11 = ASR1.
- `req_op` input, 2 bits: ALU opcode, passed through unchanged. 00 = add, 01 = sub, 10 = and, 11 = not B.
- `out_valid` output, 1 bit: operands are present for the ALU.
- `out_ready` input, 1 bit: the ALU side consumes the operands this cycle.
- `val_A` output, 16 bits: registered A operand.
- `val_B` output, 16 bits: registered, shifted B operand.
- `ALU_op` output, 2 bits: registered opcode.
- `wb_en` input, 1 bit: write-back enable.
- `wb_addr` input, 3 bits: write-back register.
- `wb_data` input, 16 bits: write-back value, normally the ALU result.

## Operation
**Accept rule**
- `req_ready = !out_valid || out_ready`. This gives a one-entry output register with no bubble under continuous flow.
- A transfer occurs when `req_valid && req_ready`.

**Operand formation on accept**
- `A = req_zero_a ? 0 : RD(rn)`.
- `Bsrc = req_use_imm ? req_imm : RD(rm)`.
- `B = shift(Bsrc, req_shift)`:
  - LSL1 drops bit 15 and inserts 0 at bit 0.
  - LSR1 inserts 0 at bit 15.
  - ASR1 replicates bit 15.
  - All results are truncated to 16 bits.

**Forwarding read `RD(x)`**
- Returns `wb_data` when `wb_en && wb_addr == x`.
- Otherwise returns `R[x]`.
- Result: a write-back and a read of the same register in the same cycle yield the new value.

**Write-back**
- `R[wb_addr] <= wb_data` when `wb_en` is high.
- Independent of the handshake; allowed every cycle, including while stalled.

**Output register**
- On accept: load `val_A`, `val_B`, `ALU_op` and set `out_valid = 1`.
- On consume without a new accept: clear `out_valid`.
- While `out_valid && !out_ready`: all outputs hold stable. Operands already captured are not re-read, so later write-backs do not alter them.

**States:** EMPTY (`out_valid = 0`) and FULL (`out_valid = 1`).
- EMPTY → FULL on accept.
- FULL → FULL on accept with `out_ready`, or on stall.
- FULL → EMPTY on `out_ready` with no request.

**Reset** (`rst_n` low at a clock edge)
- All 8 registers cleared to 0.
- `out_valid = 0`, `val_A = 0`, `val_B = 0`, `ALU_op = 00`.
- Reset wins over simultaneous accept and write-back. An in-flight operand is discarded.
- `req_ready` is 1 in the first cycle after reset.

## Timing
- Latency: a request accepted at edge N has its operands on `val_A`/`val_B`/`ALU_op` with `out_valid = 1` immediately after edge N. The ALU result is combinational in that same cycle.
- Throughput: 1 request per cycle while `out_ready` is held high.
- `req_ready` is combinational from `out_valid` and `out_ready` only. No path from `req_valid` to `req_ready`.
- Write-back is visible to a read in the same cycle through forwarding, and visible from the register array from the next cycle.
- Simultaneous write-back to register x and a read of x with `req_zero_a = 1`: A = 0. Zero-select overrides forwarding.

## Structure
- Shared package `cpu_pkg`:
  - `alu_op_t` enum: ADD, SUB, AND, NOTB.
  - `shift_t` enum: NONE, LSL1, LSR1, ASR1.
  - `reg_addr_t` (3 bits) and `word_t` (16 bits).
  - The ALU adopts the same `alu_op_t`.
- One sub-module, `regfile`:
  - 8×16 storage, two combinational read ports, one synchronous write port, synchronous active-low clear.
  - Forwarding muxes and the shifter live in `alu_operand_stage`.

## Test plan
- **Reset/basic:** hold `rst_n = 0` for 2 cycles, then write-back R1 = 0x0005 and R2 = 0x0003. Request rn = 1, rm = 2, op = SUB, shift = NONE → next cycle `val_A = 0x0005`, `val_B = 0x0003`, `ALU_op = 01`, `out_valid = 1`. All outputs read 0 during reset.
- **Shifter:** immediate B = 0x8001 with each shift code → NONE 0x8001, LSL1 0x0002, LSR1 0x4000, ASR1 0xC000.
- **Forwarding:** write-back R3 = 0xBEEF in the same cycle as a request with rn = 3, rm = 3 → `val_A = val_B = 0xBEEF`. With `req_zero_a = 1`, `val_A = 0x0000`.
- **Backpressure:** `out_ready = 0` for 3 cycles with `req_valid` held → `req_ready = 0`, outputs stable, and a write-back to the captured source does not change `val_A`. Raise `out_ready` → next operands load the following cycle with no lost or duplicated request.
- **Streaming:** 8 back-to-back requests with `out_ready = 1` → 8 consecutive `out_valid` cycles in order.
- **Reset mid-operation:** assert reset while FULL and stalled → `out_valid = 0` and R1 reads 0 after reset.
